// File: rtl/demux16_collector.sv
`default_nettype none
// ============================================================================
// Module   : demux16_collector
// Purpose  : Serial-to-parallel collector. It steers each accepted input bit
//            into one of WIDTH word positions. The position comes from an
//            auto-increment pointer or from an explicit select. Once every
//            position has been written, the word is offered on a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module demux16_collector #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel_mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] wr_mask,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_LSB     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] c_PTR_INC = {{(SEL_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_mask;
    logic [SEL_W-1:0] r_ptr;
    logic             r_mode;
    logic             r_busy;

    logic [SEL_W-1:0] w_idx;
    logic [WIDTH-1:0] w_onehot;
    logic [WIDTH-1:0] w_mask_next;
    logic             w_accept;
    logic             w_done;
    logic             w_init;

    // Write-position decode, acceptance and completion detection
    always_comb begin
        w_idx       = r_mode ? sel : r_ptr;
        w_onehot    = c_LSB << w_idx;
        w_accept    = (r_state == ST_FILL) && din_valid;
        w_mask_next = r_mask | w_onehot;
        w_done      = w_accept && (&w_mask_next);
        // A new collection starts from IDLE, or from HOLD in the same cycle
        // that the finished word is taken, so back-to-back words need no gap.
        w_init      = start && ((r_state == ST_IDLE) ||
                                ((r_state == ST_HOLD) && word_ready));
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_done) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    w_state_next = start ? ST_FILL : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Word, written-mask, pointer and mode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_mask <= '0;
            r_ptr  <= '0;
            r_mode <= 1'b0;
        end else if (w_init) begin
            // The word is left as is, so the last result stays visible.
            r_mask <= '0;
            r_ptr  <= '0;
            r_mode <= sel_mode;
        end else if (w_accept) begin
            r_word[w_idx] <= din;
            r_mask        <= w_mask_next;
            if (!r_mode) begin
                r_ptr <= r_ptr + c_PTR_INC;
            end
        end
    end

    // Registered busy flag, taken from the next state so it tracks the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
        end
    end

    assign din_ready  = (r_state == ST_FILL);
    assign word_valid = (r_state == ST_HOLD);
    assign word       = r_word;
    assign wr_mask    = r_mask;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_demux16_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux16_collector
// Purpose  : Directed, self-checking bench for demux16_collector
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux16_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel_mode = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        word_ready = 1'b0;
    logic        din_ready;
    logic [15:0] word;
    logic        word_valid;
    logic [15:0] wr_mask;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    demux16_collector #(.WIDTH(16), .SEL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sel_mode   (sel_mode),
        .sel        (sel),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .wr_mask    (wr_mask),
        .busy       (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;   // 0 auto, 1 explicit
        logic        desc;   // explicit order 15..0 when set
        logic        gaps;   // idle cycle between accepted bits
        int          hold;   // cycles of backpressure in HOLD
        logic [15:0] data;   // bit source
        logic [15:0] exp;    // expected assembled word
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_collect(input logic mode);
        start    = 1'b1;
        sel_mode = mode;
        step();
        start    = 1'b0;
        sel_mode = ~mode;   // must be ignored once latched
        chk("start_busy", busy, 1);
        chk("start_din_ready", din_ready, 1);
        chk("start_mask", wr_mask, 16'h0000);
        chk("start_word_valid", word_valid, 0);
    endtask

    task automatic feed(input logic mode, input logic desc, input logic gaps,
                        input logic start_mid, input logic [15:0] data);
        logic [3:0] idx;
        for (int k = 0; k < 16; k++) begin
            idx = 4'(desc ? 15 - k : k);
            if (gaps && k > 0) begin
                din_valid = 1'b0;
                din       = ~data[idx];
                sel       = ~idx;
                step();
            end
            if (start_mid && k >= 8) start = 1'b1;
            din_valid = 1'b1;
            din       = data[idx];
            sel       = mode ? idx : ~idx;
            step();
            din_valid = 1'b0;
            if (k < 15) chk("no_early_valid", word_valid, 0);
        end
        start = 1'b0;
        chk("done_valid", word_valid, 1);
        chk("done_din_ready", din_ready, 0);
        chk("done_busy", busy, 1);
        chk("done_mask", wr_mask, 16'hFFFF);
    endtask

    task automatic finish_hold(input int hold, input logic [15:0] exp);
        chk("hold_word", word, exp);
        for (int c = 0; c < hold; c++) begin
            word_ready = 1'b0;
            step();
            chk("bp_valid", word_valid, 1);
            chk("bp_word", word, exp);
        end
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        chk("acc_valid", word_valid, 0);
        chk("acc_busy", busy, 0);
        chk("acc_din_ready", din_ready, 0);
        chk("acc_word_kept", word, exp);
    endtask

    initial begin
        logic [15:0] pat;

        vecs[0] = '{mode: 1'b0, desc: 1'b0, gaps: 1'b0, hold: 0, data: 16'hB53C, exp: 16'hB53C};
        vecs[1] = '{mode: 1'b1, desc: 1'b1, gaps: 1'b0, hold: 0, data: 16'hA5F0, exp: 16'hA5F0};
        vecs[2] = '{mode: 1'b0, desc: 1'b0, gaps: 1'b1, hold: 5, data: 16'hB53C, exp: 16'hB53C};
        vecs[3] = '{mode: 1'b1, desc: 1'b0, gaps: 1'b1, hold: 2, data: 16'h0F0F, exp: 16'h0F0F};
        vecs[4] = '{mode: 1'b0, desc: 1'b0, gaps: 1'b0, hold: 1, data: 16'h1234, exp: 16'h1234};

        // Reset state
        #12;
        chk("rst_word", word, 16'h0000);
        chk("rst_mask", wr_mask, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_word_valid", word_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven collections
        for (int v = 0; v < 5; v++) begin
            begin_collect(vecs[v].mode);
            feed(vecs[v].mode, vecs[v].desc, vecs[v].gaps, 1'b0, vecs[v].data);
            finish_hold(vecs[v].hold, vecs[v].exp);
        end

        // Explicit mode: rewriting a position overwrites without completing
        begin_collect(1'b1);
        din_valid = 1'b1; sel = 4'd3; din = 1'b1;
        step();
        chk("rw1_mask", wr_mask, 16'h0008);
        chk("rw1_bit3", word[3], 1);
        din = 1'b0;
        step();
        chk("rw2_mask", wr_mask, 16'h0008);
        chk("rw2_bit3", word[3], 0);
        chk("rw2_valid", word_valid, 0);
        pat = 16'h8421;
        for (int p = 0; p < 16; p++) begin
            if (p != 3) begin
                sel = 4'(p);
                din = pat[p];
                step();
                if (p < 15) chk("rw_no_early_valid", word_valid, 0);
            end
        end
        din_valid = 1'b0;
        chk("rw_done_valid", word_valid, 1);
        chk("rw_done_mask", wr_mask, 16'hFFFF);
        finish_hold(0, 16'h8421);

        // Back-to-back: accept and restart in the same cycle
        begin_collect(1'b0);
        feed(1'b0, 1'b0, 1'b0, 1'b0, 16'hB53C);
        chk("b2b_first_word", word, 16'hB53C);
        word_ready = 1'b1; start = 1'b1; sel_mode = 1'b0;
        step();
        word_ready = 1'b0; start = 1'b0; sel_mode = 1'b1;
        chk("b2b_valid", word_valid, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_din_ready", din_ready, 1);
        chk("b2b_mask", wr_mask, 16'h0000);
        feed(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);
        finish_hold(0, 16'h1234);

        // Asynchronous reset in the middle of a collection
        begin_collect(1'b0);
        din_valid = 1'b1; din = 1'b1;
        for (int k = 0; k < 7; k++) step();
        din_valid = 1'b0;
        chk("pre_rst_mask", wr_mask, 16'h007F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_word", word, 16'h0000);
        chk("arst_mask", wr_mask, 16'h0000);
        chk("arst_busy", busy, 0);
        chk("arst_din_ready", din_ready, 0);
        chk("arst_valid", word_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        begin_collect(1'b0);
        feed(1'b0, 1'b0, 1'b0, 1'b0, 16'h5A5A);
        finish_hold(0, 16'h5A5A);

        // Ignored inputs: din_valid in IDLE, start during FILL
        din_valid = 1'b1; din = 1'b0; sel = 4'd0;
        step();
        step();
        din_valid = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_word", word, 16'h5A5A);
        begin_collect(1'b0);
        feed(1'b0, 1'b0, 1'b0, 1'b1, 16'hC0DE);
        finish_hold(0, 16'hC0DE);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
